// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg : shared size encodings, FSM state type and capacity for the RAM responder
// Rev 1.0
// ============================================================================
package ram_pkg;

  localparam int MEM_BYTES = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_byte_array.sv
`default_nettype none
// ============================================================================
// ram_byte_array : four 8-bit lanes, per-lane write enables, combinational word read
// Rev 1.0
// ============================================================================
module ram_byte_array #(
  parameter  int MEM_BYTES = 512,
  localparam int WORDS     = MEM_BYTES / 4,
  localparam int IDX_W     = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] word_idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // Lane 3 holds the lowest byte address of each word (big-endian)
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk) begin
      if (we[l]) begin
        mem[word_idx] <= wdata[8*l +: 8];
      end
    end

    assign rdata[8*l +: 8] = mem[word_idx];
  end

endmodule : ram_byte_array
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// ram_responder : MFA/MFC handshake RAM with wait states, big-endian sized access
// Rev 1.0
// ============================================================================
module ram_responder #(
  parameter int WAIT_STATES = 2,
  parameter int MEM_BYTES   = 512
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        ramMFA,
  input  logic        ramRW,
  input  logic [1:0]  ramDataSize,
  input  logic [8:0]  ramAddress,
  input  logic [31:0] ramDataIn,
  output logic [31:0] ramDataOut,
  output logic        ramMFC,
  output logic        ramErr
);
  import ram_pkg::*;

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic        mfc_q, mfc_d;
  logic        err_q, err_d;

  logic [1:0]  w_offset;
  logic        w_misaligned;
  logic [3:0]  w_lane_mask;
  logic [3:0]  w_lane_we;
  logic [31:0] w_wr_data;
  logic [31:0] w_rd_word;
  logic [31:0] w_rd_data;

  ram_byte_array #(
    .MEM_BYTES (MEM_BYTES)
  ) u_array (
    .clk      (Clk),
    .we       (w_lane_we),
    .word_idx (addr_q[IDX_W+1:2]),
    .wdata    (w_wr_data),
    .rdata    (w_rd_word)
  );

  assign w_offset     = addr_q[1:0];
  assign w_misaligned = (size_q == SIZE_BAD) ||
                        ((size_q == SIZE_HALF) && w_offset[0]) ||
                        ((size_q == SIZE_WORD) && (w_offset != 2'b00));

  // Lane masks and read shifts count from the MSB lane, so offset 0 lands on bits 31:24
  always_comb begin
    w_lane_mask = 4'b0000;
    w_wr_data   = din_q;
    w_rd_data   = 32'h0000_0000;
    case (size_q)
      SIZE_BYTE: begin
        w_lane_mask = 4'b1000 >> w_offset;
        w_wr_data   = {4{din_q[7:0]}};
        w_rd_data   = (w_rd_word >> {~w_offset, 3'b000}) & 32'h0000_00FF;
      end
      SIZE_HALF: begin
        w_lane_mask = 4'b1100 >> w_offset;
        w_wr_data   = {2{din_q[15:0]}};
        w_rd_data   = (w_rd_word >> {~w_offset[1], 4'b0000}) & 32'h0000_FFFF;
      end
      SIZE_WORD: begin
        w_lane_mask = 4'b1111;
        w_wr_data   = din_q;
        w_rd_data   = w_rd_word;
      end
      default: begin
        w_lane_mask = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    size_d    = size_q;
    addr_d    = addr_q;
    din_d     = din_q;
    dout_d    = dout_q;
    mfc_d     = mfc_q;
    err_d     = err_q;
    w_lane_we = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (ramMFA) begin
          rw_d    = ramRW;
          size_d  = ramDataSize;
          addr_d  = ramAddress;
          din_d   = ramDataIn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A dropped request wins over completion, so an abort never commits
        if (!ramMFA) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          err_d   = w_misaligned;
          if (!w_misaligned) begin
            if (rw_q) begin
              dout_d = w_rd_data;
            end else begin
              w_lane_we = w_lane_mask;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!ramMFA) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mfc_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= 9'd0;
      din_q   <= 32'h0000_0000;
      dout_q  <= 32'h0000_0000;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  assign ramDataOut = dout_q;
  assign ramMFC     = mfc_q;
  assign ramErr     = err_q;

endmodule : ram_responder
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// tb_ram_responder : randomized self-checking bench with a byte-array reference model
// Rev 1.0
// ============================================================================
module tb_ram_responder;

  localparam int WS = 2;

  logic        Clk;
  logic        reset;
  logic        ramMFA, ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] ramDataIn, ramDataOut;
  logic        ramMFC, ramErr;

  logic        m0_mfa, m0_rw;
  logic [1:0]  m0_size;
  logic [8:0]  m0_addr;
  logic [31:0] m0_din, m0_dout;
  logic        m0_mfc, m0_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model_mem [512];
  logic [31:0] exp_dout;

  ram_responder #(.WAIT_STATES(WS), .MEM_BYTES(512)) dut (
    .Clk(Clk), .reset(reset), .ramMFA(ramMFA), .ramRW(ramRW),
    .ramDataSize(ramDataSize), .ramAddress(ramAddress), .ramDataIn(ramDataIn),
    .ramDataOut(ramDataOut), .ramMFC(ramMFC), .ramErr(ramErr)
  );

  ram_responder #(.WAIT_STATES(0), .MEM_BYTES(512)) dut0 (
    .Clk(Clk), .reset(reset), .ramMFA(m0_mfa), .ramRW(m0_rw),
    .ramDataSize(m0_size), .ramAddress(m0_addr), .ramDataIn(m0_din),
    .ramDataOut(m0_dout), .ramMFC(m0_mfc), .ramErr(m0_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Full access through the handshake; the model predicts err, data and latency
  task automatic access(input logic rw, input logic [1:0] size, input logic [8:0] addr,
                        input logic [31:0] din, input int hold);
    int   lat;
    int   a;
    logic bad;
    a   = int'(addr);
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    if (!bad) begin
      if (rw) begin
        case (size)
          2'b00:   exp_dout = {24'h0, model_mem[a]};
          2'b01:   exp_dout = {16'h0, model_mem[a], model_mem[a+1]};
          default: exp_dout = {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
        endcase
      end else begin
        case (size)
          2'b00: model_mem[a] = din[7:0];
          2'b01: begin model_mem[a] = din[15:8]; model_mem[a+1] = din[7:0]; end
          default: begin
            model_mem[a]   = din[31:24]; model_mem[a+1] = din[23:16];
            model_mem[a+2] = din[15:8];  model_mem[a+3] = din[7:0];
          end
        endcase
      end
    end
    ramMFA = 1'b1; ramRW = rw; ramDataSize = size; ramAddress = addr; ramDataIn = din;
    tick();
    ramRW = 1'($urandom); ramDataSize = 2'($urandom); ramAddress = 9'($urandom);
    ramDataIn = $urandom;
    lat = 0;
    while (ramMFC !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 1 + WS) begin
      n_fail++;
      $display("FAIL latency addr=%h: got %0d cycles, expected %0d", addr, lat, 1 + WS);
    end
    n_tests++;
    if (ramErr !== bad) begin
      n_fail++;
      $display("FAIL err addr=%h size=%b: got %b, expected %b", addr, size, ramErr, bad);
    end
    n_tests++;
    if (ramDataOut !== exp_dout) begin
      n_fail++;
      $display("FAIL data addr=%h size=%b rw=%b: got %h, expected %h", addr, size, rw, ramDataOut, exp_dout);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      n_tests++;
      if (ramMFC !== 1'b1 || ramDataOut !== exp_dout || ramErr !== bad) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got mfc=%b data=%h err=%b, expected mfc=1 data=%h err=%b",
                 i, ramMFC, ramDataOut, ramErr, exp_dout, bad);
      end
    end
    ramMFA = 1'b0;
    tick();
    n_tests++;
    if (ramMFC !== 1'b0 || ramErr !== 1'b0 || ramDataOut !== exp_dout) begin
      n_fail++;
      $display("FAIL release: got mfc=%b err=%b data=%h, expected mfc=0 err=0 data=%h",
               ramMFC, ramErr, ramDataOut, exp_dout);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (ramMFC !== 1'b0 || ramErr !== 1'b0 || ramDataOut !== 32'h0) begin
      n_fail++;
      $display("FAIL reset state: got mfc=%b err=%b data=%h, expected 0 0 00000000", ramMFC, ramErr, ramDataOut);
    end
    exp_dout = 32'h0;
  endtask

  task automatic test_fill();
    for (int w = 0; w < 128; w++) begin
      access(1'b0, 2'b10, 9'(w * 4), $urandom, 0);
    end
  endtask

  task automatic test_directed();
    access(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0);
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    n_tests++;
    if (ramDataOut !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL directed word: got %h, expected deadbeef", ramDataOut);
    end
    access(1'b1, 2'b00, 9'h010, 32'h0, 0);
    access(1'b1, 2'b00, 9'h011, 32'h0, 0);
    access(1'b1, 2'b00, 9'h012, 32'h0, 0);
    access(1'b1, 2'b00, 9'h013, 32'h0, 0);
    n_tests++;
    if (ramDataOut !== 32'h000000EF) begin
      n_fail++;
      $display("FAIL directed byte 013: got %h, expected 000000ef", ramDataOut);
    end
    access(1'b1, 2'b01, 9'h012, 32'h0, 0);
    n_tests++;
    if (ramDataOut !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL directed half 012: got %h, expected 0000beef", ramDataOut);
    end
  endtask

  task automatic test_misaligned();
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    access(1'b0, 2'b01, 9'h011, 32'h00001234, 0);
    access(1'b1, 2'b10, 9'h002, 32'h0, 0);
    access(1'b1, 2'b11, 9'h010, 32'h0, 0);
    access(1'b0, 2'b11, 9'h010, 32'h0, 0);
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    n_tests++;
    if (ramDataOut !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL misaligned left memory: got %h, expected deadbeef", ramDataOut);
    end
  endtask

  task automatic test_abort();
    ramMFA = 1'b1; ramRW = 1'b0; ramDataSize = 2'b10; ramAddress = 9'h020; ramDataIn = 32'hFFFFFFFF;
    tick();
    ramMFA = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (ramMFC !== 1'b0) begin
        n_fail++;
        $display("FAIL abort mfc cycle %0d: got %b, expected 0", i, ramMFC);
      end
    end
    access(1'b1, 2'b10, 9'h020, 32'h0, 0);
  endtask

  task automatic test_hold();
    access(1'b0, 2'b01, 9'h0A2, $urandom, 5);
    access(1'b1, 2'b10, 9'h0A0, 32'h0, 5);
  endtask

  task automatic test_zero_wait();
    int   lat;
    logic [31:0] d;
    d = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      m0_mfa = 1'b1; m0_rw = 1'(pass); m0_size = 2'b10; m0_addr = 9'h040; m0_din = d;
      tick();
      lat = 0;
      while (m0_mfc !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      n_tests++;
      if (lat != 1) begin
        n_fail++;
        $display("FAIL zero-wait latency pass %0d: got %0d, expected 1", pass, lat);
      end
      m0_mfa = 1'b0;
      tick();
    end
    n_tests++;
    if (m0_dout !== d || m0_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero-wait data: got %h err=%b, expected %h err=0", m0_dout, m0_err, d);
    end
  endtask

  task automatic test_reset_mid();
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    ramMFA = 1'b1; ramRW = 1'b0; ramDataSize = 2'b10; ramAddress = 9'h030; ramDataIn = ~exp_dout;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (ramMFC !== 1'b0 || ramErr !== 1'b0 || ramDataOut !== 32'h0) begin
      n_fail++;
      $display("FAIL async reset: got mfc=%b err=%b data=%h, expected 0 0 00000000", ramMFC, ramErr, ramDataOut);
    end
    ramMFA = 1'b0;
    #2 reset = 1'b0;
    exp_dout = 32'h0;
    tick();
    tick();
    access(1'b1, 2'b10, 9'h030, 32'h0, 0);
    access(1'b1, 2'b10, 9'h010, 32'h0, 0);
    n_tests++;
    if (ramDataOut !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL data across reset: got %h, expected deadbeef", ramDataOut);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) access(1'b0, 2'b00, 9'(9'h100 + i), $urandom, 0);
    access(1'b1, 2'b10, 9'h100, 32'h0, 0);
    access(1'b0, 2'b01, 9'h102, $urandom, 0);
    access(1'b1, 2'b10, 9'h100, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [1:0] size;
    logic [8:0] addr;
    for (int i = 0; i < 150; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      access(1'($urandom), size, addr, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    reset = 1'b1;
    ramMFA = 1'b0; ramRW = 1'b0; ramDataSize = 2'b00; ramAddress = 9'h0; ramDataIn = 32'h0;
    m0_mfa = 1'b0; m0_rw = 1'b0; m0_size = 2'b00; m0_addr = 9'h0; m0_din = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    reset = 1'b0;
    tick();
    test_fill();
    test_directed();
    test_misaligned();
    test_abort();
    test_hold();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_responder
`default_nettype wire
